// File: rtl/matrix_scan_pkg.sv
// Shared definitions for the matrix scan controller: FSM state encoding,
// default parameter values and a helper to size the shared timer.
package matrix_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CONVERT = 3'd2,
        ST_NEXT    = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_e;

    localparam int DEF_ROWS        = 2;
    localparam int DEF_COLS        = 2;
    localparam int DEF_WIDTH       = 5;
    localparam int DEF_SETTLE_CYC  = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

    // Bits needed to hold the larger of the two timer load values.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter shared by settle and ADC-timeout timing.
// expire_o marks the final cycle of a loaded interval (count == 1).
module scan_timer #(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load_i) begin
            count <= load_val_i;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire_o = (count == W'(1));

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-major scan of a mux matrix: settle each pixel address, trigger one
// ADC conversion, wait for completion (with timeout), then advance.
module matrix_scan_ctrl
    import matrix_scan_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int Width       = DEF_WIDTH,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             adc_done_i,
    output logic [Width-1:0] row_o,
    output logic [Width-1:0] col_o,
    output logic             mux_en_o,
    output logic             adc_start_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             err_o
);

    localparam int TimerW = timer_width(SETTLE_CYC, TIMEOUT_CYC);
    localparam logic [Width-1:0]  LastRow     = Width'(ROWS - 1);
    localparam logic [Width-1:0]  LastCol     = Width'(COLS - 1);
    localparam logic [TimerW-1:0] SettleLoad  = TimerW'(SETTLE_CYC);
    localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYC);

    scan_state_e       state;
    logic              tmr_load;
    logic [TimerW-1:0] tmr_val;
    logic              tmr_expire;
    logic              last_pixel;
    logic              done_ok;

    assign last_pixel = (row_o == LastRow) && (col_o == LastCol);
    // The trigger cycle itself is excluded: adc_start_o is still high then.
    assign done_ok    = (state == ST_CONVERT) && !adc_start_o && adc_done_i;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SettleLoad;
        case (state)
            ST_IDLE:   tmr_load = start_i;
            ST_SETTLE: begin
                tmr_load = tmr_expire;
                tmr_val  = TimeoutLoad;
            end
            ST_NEXT:   tmr_load = !last_pixel;
            default:   tmr_load = 1'b0;
        endcase
    end

    scan_timer #(
        .W(TimerW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // Addresses only move together with a rising mux_en_o, so the mux never
    // sees an address change while it is driving.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            row_o        <= '0;
            col_o        <= '0;
            mux_en_o     <= 1'b0;
            adc_start_o  <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    frame_done_o <= 1'b0;
                    adc_start_o  <= 1'b0;
                    if (start_i) begin
                        row_o    <= '0;
                        col_o    <= '0;
                        err_o    <= 1'b0;
                        busy_o   <= 1'b1;
                        mux_en_o <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expire) begin
                        adc_start_o <= 1'b1;
                        state       <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    adc_start_o <= 1'b0;
                    if (done_ok) begin
                        mux_en_o <= 1'b0;
                        state    <= ST_NEXT;
                    end else if (tmr_expire) begin
                        err_o    <= 1'b1;
                        mux_en_o <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_NEXT: begin
                    if (last_pixel) begin
                        frame_done_o <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        if (col_o == LastCol) begin
                            col_o <= '0;
                            row_o <= row_o + Width'(1);
                        end else begin
                            col_o <= col_o + Width'(1);
                        end
                        mux_en_o <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    frame_done_o <= 1'b0;
                    busy_o       <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    mux_en_o    <= 1'b0;
                    adc_start_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: per-cycle expectations are built
// from a per-pixel timeline (settle, convert, next) rather than an FSM copy.
module tb_matrix_scan_ctrl;

    localparam int ROWS    = 2;
    localparam int COLS    = 2;
    localparam int WIDTH   = 5;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 8;
    localparam int NPIX    = ROWS * COLS;

    logic             clk_i      = 1'b0;
    logic             rst_i      = 1'b1;
    logic             start_i    = 1'b0;
    logic             adc_done_i = 1'b0;
    logic [WIDTH-1:0] row_o;
    logic [WIDTH-1:0] col_o;
    logic             mux_en_o;
    logic             adc_start_o;
    logic             busy_o;
    logic             frame_done_o;
    logic             err_o;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    int as_cnt   = 0;
    int m_row    = 0;
    int m_col    = 0;
    bit m_err    = 1'b0;

    typedef struct {
        bit start;
        bit done;
        bit busy;
        bit mux;
        bit adcs;
        bit fd;
        bit err;
        int row;
        int col;
    } cyc_rec_t;

    // dly holds one 4-bit done delay per pixel (nibble p = pixel p); mode
    // 0 = quiet, 1 = stray start/done pulses, 2 = start held high.
    typedef struct {
        logic [15:0] dly;
        int          mode;
        int          gap;
        int          exp_fd;
        int          exp_adcs;
        bit          exp_err;
    } frame_vec_t;

    cyc_rec_t q[$];

    matrix_scan_ctrl #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .Width       (WIDTH),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .adc_done_i   (adc_done_i),
        .row_o        (row_o),
        .col_o        (col_o),
        .mux_en_o     (mux_en_o),
        .adc_start_o  (adc_start_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic cyc_rec_t mk(input bit busy, input bit mux, input bit adcs,
                                    input bit fd, input bit err, input int row, input int col);
        cyc_rec_t r;
        r.start = 1'b0;
        r.done  = 1'b0;
        r.busy  = busy;
        r.mux   = mux;
        r.adcs  = adcs;
        r.fd    = fd;
        r.err   = err;
        r.row   = row;
        r.col   = col;
        return r;
    endfunction

    function automatic bit noise_start(input int mode);
        return (mode == 2) || ((mode == 1) && ($urandom_range(0, 3) == 0));
    endfunction

    function automatic bit noise_done(input int mode);
        return (mode != 0) && ($urandom_range(0, 3) == 0);
    endfunction

    task automatic build_frame(input logic [15:0] dly, input int mode);
        cyc_rec_t r;
        int row, col, d, conv_len;
        bit ok;
        r = mk(0, 0, 0, 0, m_err, m_row, m_col);
        r.start = 1'b1;
        q.push_back(r);
        for (int p = 0; p < NPIX; p++) begin
            row = p / COLS;
            col = p % COLS;
            d   = int'(dly[p*4 +: 4]);
            ok  = (d >= 1) && (d <= TIMEOUT - 1);
            conv_len = ok ? d + 1 : TIMEOUT;
            for (int k = 0; k < SETTLE; k++) begin
                r = mk(1, 1, 0, 0, 0, row, col);
                r.start = noise_start(mode) || (mode == 1 && p == 2 && k == 1);
                r.done  = noise_done(mode) || (mode == 1 && k == 0);
                q.push_back(r);
            end
            for (int k = 0; k < conv_len; k++) begin
                r = mk(1, 1, k == 0, 0, 0, row, col);
                r.start = noise_start(mode);
                r.done  = (ok && k == d) || (k == 0 && mode == 1);
                q.push_back(r);
            end
            if (!ok) begin
                m_err = 1'b1;
                m_row = row;
                m_col = col;
                return;
            end
            r = mk(1, 0, 0, 0, 0, row, col);
            r.start = noise_start(mode);
            r.done  = noise_done(mode);
            q.push_back(r);
        end
        r = mk(1, 0, 0, 1, 0, ROWS - 1, COLS - 1);
        r.start = noise_start(mode);
        r.done  = noise_done(mode);
        q.push_back(r);
        m_row = ROWS - 1;
        m_col = COLS - 1;
        m_err = 1'b0;
    endtask

    task automatic build_idle(input int n, input int mode);
        cyc_rec_t r;
        for (int i = 0; i < n; i++) begin
            r = mk(0, 0, 0, 0, m_err, m_row, m_col);
            r.done = noise_done(mode);
            q.push_back(r);
        end
    endtask

    // Drives each record's inputs at a falling edge and compares the
    // registered outputs of that same cycle.
    task automatic apply_stimulus(input string lbl, input int abort_at);
        for (int i = 0; i < q.size(); i++) begin
            start_i    = q[i].start;
            adc_done_i = q[i].done;
            if (frame_done_o) fd_cnt++;
            if (adc_start_o)  as_cnt++;
            check_output($sformatf("%s.busy@%0d", lbl, i),  int'(busy_o),       int'(q[i].busy));
            check_output($sformatf("%s.mux@%0d", lbl, i),   int'(mux_en_o),     int'(q[i].mux));
            check_output($sformatf("%s.adcs@%0d", lbl, i),  int'(adc_start_o),  int'(q[i].adcs));
            check_output($sformatf("%s.fdone@%0d", lbl, i), int'(frame_done_o), int'(q[i].fd));
            check_output($sformatf("%s.err@%0d", lbl, i),   int'(err_o),        int'(q[i].err));
            check_output($sformatf("%s.row@%0d", lbl, i),   int'(row_o),        q[i].row);
            check_output($sformatf("%s.col@%0d", lbl, i),   int'(col_o),        q[i].col);
            if (i == abort_at) begin
                q.delete();
                return;
            end
            @(negedge clk_i);
        end
        start_i    = 1'b0;
        adc_done_i = 1'b0;
        q.delete();
    endtask

    task automatic check_all_zero(input string lbl);
        check_output({lbl, ".busy"},  int'(busy_o),       0);
        check_output({lbl, ".mux"},   int'(mux_en_o),     0);
        check_output({lbl, ".adcs"},  int'(adc_start_o),  0);
        check_output({lbl, ".fdone"}, int'(frame_done_o), 0);
        check_output({lbl, ".err"},   int'(err_o),        0);
        check_output({lbl, ".row"},   int'(row_o),        0);
        check_output({lbl, ".col"},   int'(col_o),        0);
    endtask

    initial begin
        frame_vec_t  vecs[5];
        logic [15:0] rdly;
        int          idx;

        vecs[0] = '{dly: 16'h3333, mode: 0, gap: 2, exp_fd: 1, exp_adcs: 4, exp_err: 1'b0};
        vecs[1] = '{dly: 16'h33F3, mode: 0, gap: 2, exp_fd: 0, exp_adcs: 2, exp_err: 1'b1};
        vecs[2] = '{dly: 16'h1111, mode: 1, gap: 0, exp_fd: 1, exp_adcs: 4, exp_err: 1'b0};
        vecs[3] = '{dly: 16'h7217, mode: 2, gap: 0, exp_fd: 1, exp_adcs: 4, exp_err: 1'b0};
        vecs[4] = '{dly: 16'h2222, mode: 2, gap: 3, exp_fd: 1, exp_adcs: 4, exp_err: 1'b0};

        #3;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        build_idle(2, 1);
        apply_stimulus("idle", -1);

        for (int v = 0; v < 5; v++) begin
            fd_cnt = 0;
            as_cnt = 0;
            build_frame(vecs[v].dly, vecs[v].mode);
            apply_stimulus($sformatf("vec%0d", v), -1);
            check_output($sformatf("vec%0d.err_end", v), int'(err_o), int'(vecs[v].exp_err));
            build_idle(vecs[v].gap, 0);
            apply_stimulus($sformatf("vec%0d.gap", v), -1);
            check_output($sformatf("vec%0d.fd_count", v), fd_cnt, vecs[v].exp_fd);
            check_output($sformatf("vec%0d.adcs_count", v), as_cnt, vecs[v].exp_adcs);
        end

        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < NPIX; p++) rdly[p*4 +: 4] = 4'($urandom_range(1, 9));
            build_frame(rdly, int'($urandom_range(0, 1)));
            apply_stimulus($sformatf("rnd%0d", r), -1);
            build_idle(int'($urandom_range(0, 2)), 1);
            apply_stimulus($sformatf("rnd%0d.gap", r), -1);
        end

        // Abort in the trigger cycle of the last pixel, then confirm the
        // scan stays dead until a fresh start.
        build_frame(16'h1111, 0);
        idx = 0;
        for (int i = 0; i < q.size(); i++) if (q[i].adcs) idx = i;
        apply_stimulus("abort", idx);
        #2 rst_i = 1'b1;
        #1 check_all_zero("abort_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        m_row  = 0;
        m_col  = 0;
        m_err  = 1'b0;
        fd_cnt = 0;
        build_idle(8, 1);
        apply_stimulus("post_rst", -1);
        check_output("post_rst.fd_count", fd_cnt, 0);
        build_frame(16'h2222, 0);
        apply_stimulus("post_rst_frame", -1);
        build_idle(2, 0);
        apply_stimulus("final_idle", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
